// File: rtl/cache_bus_arbiter_if.sv
// Signal bundle between the two caches, the memory bus and cache_bus_arbiter.
// Modport slave is the arbiter's view; master is the environment (caches and memory).
interface cache_bus_arbiter_if #(
   parameter int ADDR_WIDTH = 64,
   parameter int LINE_WIDTH = 1024
);
   // Handshake: a cache holds reqN_valid with a stable command until the arbiter
   // returns a one-cycle reqN_rvalid (fill) or reqN_wready (store). Memory sees
   // mem_valid high for the whole command and answers with a one-cycle
   // mem_rvalid/mem_wready; mem_valid dropping early means the command is abandoned.
   logic                  req0_valid,  req1_valid;
   logic                  req0_store,  req1_store;
   logic                  req0_rready, req1_rready;
   logic [ADDR_WIDTH-1:0] req0_addr,   req1_addr;
   logic [LINE_WIDTH-1:0] req0_wdata,  req1_wdata;
   logic [LINE_WIDTH-1:0] req0_rdata,  req1_rdata;
   logic                  req0_rvalid, req1_rvalid;
   logic                  req0_wready, req1_wready;
   logic                  inv0,        inv1;
   logic [ADDR_WIDTH-1:0] inv0_addr,   inv1_addr;
   logic                  inv0_ack,    inv1_ack;
   logic                  mem_valid;
   logic                  mem_store;
   logic                  mem_rready;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [LINE_WIDTH-1:0] mem_wdata;
   logic [LINE_WIDTH-1:0] mem_rdata;
   logic                  mem_rvalid;
   logic                  mem_wready;
   logic [1:0]            dbg_state;

   modport slave (
      input  req0_valid, req0_store, req0_rready, req0_addr, req0_wdata,
      input  req1_valid, req1_store, req1_rready, req1_addr, req1_wdata,
      input  inv0_ack, inv1_ack, mem_rdata, mem_rvalid, mem_wready,
      output req0_rdata, req0_rvalid, req0_wready,
      output req1_rdata, req1_rvalid, req1_wready,
      output inv0, inv0_addr, inv1, inv1_addr,
      output mem_valid, mem_store, mem_rready, mem_addr, mem_wdata,
      output dbg_state
   );

   modport master (
      output req0_valid, req0_store, req0_rready, req0_addr, req0_wdata,
      output req1_valid, req1_store, req1_rready, req1_addr, req1_wdata,
      output inv0_ack, inv1_ack, mem_rdata, mem_rvalid, mem_wready,
      input  req0_rdata, req0_rvalid, req0_wready,
      input  req1_rdata, req1_rvalid, req1_wready,
      input  inv0, inv0_addr, inv1, inv1_addr,
      input  mem_valid, mem_store, mem_rready, mem_addr, mem_wdata,
      input  dbg_state
   );
endinterface

// File: rtl/cache_bus_arbiter.sv
// Round-robin arbiter sharing one line-wide memory bus between the I-cache (port 0)
// and D-cache (port 1), with a post-store invalidate sent to the other cache.
module cache_bus_arbiter #(
   parameter int ADDR_WIDTH = 64,
   parameter int LINE_WIDTH = 1024,
   parameter bit SNOOP_EN   = 1'b1
) (
   input logic                clk,
   input logic                reset,
   cache_bus_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, INVAL = 2'd2} state_e;

   state_e                state_q, state_d;
   logic                  gnt_q, gnt_d;
   logic                  prio_q, prio_d;
   logic                  store_q, store_d;
   logic                  rready_q, rready_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [LINE_WIDTH-1:0] wdata_q, wdata_d;

   logic win;
   logic fill_done;
   logic store_done;
   logic inv_ack;

   // A lone requester wins outright; a tie goes to the prio port.
   assign win        = (bus.req0_valid & bus.req1_valid) ? prio_q : bus.req1_valid;
   assign fill_done  = ~store_q & bus.mem_rvalid;
   assign store_done = store_q & bus.mem_wready;
   assign inv_ack    = gnt_q ? bus.inv0_ack : bus.inv1_ack;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         gnt_q    <= 1'b0;
         prio_q   <= 1'b0;
         store_q  <= 1'b0;
         rready_q <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         prio_q   <= prio_d;
         store_q  <= store_d;
         rready_q <= rready_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      prio_d   = prio_q;
      store_d  = store_q;
      rready_d = rready_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      case (state_q)
         IDLE: begin
            if (bus.req0_valid | bus.req1_valid) begin
               state_d  = BUSY;
               gnt_d    = win;
               prio_d   = ~win;
               store_d  = win ? bus.req1_store  : bus.req0_store;
               rready_d = win ? bus.req1_rready : bus.req0_rready;
               addr_d   = win ? bus.req1_addr   : bus.req0_addr;
               wdata_d  = win ? bus.req1_wdata  : bus.req0_wdata;
            end
         end
         BUSY: begin
            // Completions of the wrong direction fall through untouched.
            if (fill_done) begin
               state_d = IDLE;
            end else if (store_done) begin
               state_d = SNOOP_EN ? INVAL : IDLE;
            end
         end
         INVAL: begin
            if (inv_ack) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.mem_valid   = 1'b0;
      bus.mem_store   = 1'b0;
      bus.mem_rready  = 1'b0;
      bus.mem_addr    = '0;
      bus.mem_wdata   = '0;
      bus.req0_rdata  = '0;
      bus.req0_rvalid = 1'b0;
      bus.req0_wready = 1'b0;
      bus.req1_rdata  = '0;
      bus.req1_rvalid = 1'b0;
      bus.req1_wready = 1'b0;
      bus.inv0        = 1'b0;
      bus.inv0_addr   = '0;
      bus.inv1        = 1'b0;
      bus.inv1_addr   = '0;
      bus.dbg_state   = state_q;
      case (state_q)
         BUSY: begin
            bus.mem_valid  = 1'b1;
            bus.mem_store  = store_q;
            bus.mem_rready = rready_q;
            bus.mem_addr   = addr_q;
            bus.mem_wdata  = wdata_q;
            if (gnt_q) begin
               bus.req1_rdata  = bus.mem_rdata;
               bus.req1_rvalid = fill_done;
               bus.req1_wready = store_done;
            end else begin
               bus.req0_rdata  = bus.mem_rdata;
               bus.req0_rvalid = fill_done;
               bus.req0_wready = store_done;
            end
         end
         INVAL: begin
            // The invalidate always targets the cache that did not store.
            if (gnt_q) begin
               bus.inv0      = 1'b1;
               bus.inv0_addr = addr_q;
            end else begin
               bus.inv1      = 1'b1;
               bus.inv1_addr = addr_q;
            end
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Bench for cache_bus_arbiter: grant table, round-robin, snoop, stability and reset
// sequences, with a queue of expected memory-bus commands.
module tb_cache_bus_arbiter;
   localparam int AW = 64;
   localparam int LW = 1024;
   localparam logic [1:0] S_IDLE = 2'd0;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   cache_bus_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus ();
   cache_bus_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) nbus ();

   cache_bus_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .SNOOP_EN(1'b1)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );
   cache_bus_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .SNOOP_EN(1'b0)) dut_ns (
      .clk(clk), .reset(reset), .bus(nbus)
   );

   typedef struct {
      logic          v0, v1, st0, st1;
      logic [AW-1:0] a0, a1;
      int            lat;
      logic          exp_port;
      logic          exp_store;
      logic [AW-1:0] exp_addr;
   } vec_t;

   vec_t        vecs [8];
   int          n_checks = 0;
   int          n_pass = 0;
   logic [AW:0] exp_q [$];
   logic [AW:0] sb_exp;
   logic        mv_prev = 1'b0;
   logic        ns_inv_seen = 1'b0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic check_wide(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got low bits %h expected low bits %h", name, act[127:0], exp[127:0]);
   endtask

   function automatic logic [LW-1:0] wpat(input logic [AW-1:0] a);
      return {16{a}};
   endfunction

   function automatic logic [LW-1:0] rpat(input logic [AW-1:0] a);
      return {16{a ^ 64'hABAB_ABAB_ABAB_ABAB}};
   endfunction

   function automatic logic any_out_main();
      return |{bus.mem_valid, bus.mem_store, bus.mem_rready, bus.mem_addr, bus.mem_wdata,
               bus.req0_rdata, bus.req1_rdata, bus.req0_rvalid, bus.req1_rvalid,
               bus.req0_wready, bus.req1_wready, bus.inv0, bus.inv1, bus.inv0_addr, bus.inv1_addr};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_mem_valid(input string name);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (bus.mem_valid) break;
      end
      check(name, 128'(bus.mem_valid), 128'(1));
   endtask

   // Scoreboard: every new command on the memory bus must match the oldest expectation.
   always @(negedge clk) begin
      if (bus.mem_valid && !mv_prev) begin
         check("sb_expected_cmd", 128'(exp_q.size() != 0), 128'(1));
         if (exp_q.size() != 0) begin
            sb_exp = exp_q.pop_front();
            check("sb_mem_cmd", 128'({bus.mem_store, bus.mem_addr}), 128'(sb_exp));
         end
      end
      mv_prev = bus.mem_valid;
      if (nbus.inv0 || nbus.inv1) ns_inv_seen = 1'b1;
   end

   task automatic run_vec(input vec_t v);
      logic [LW-1:0] rd;
      rd = rpat(v.exp_addr);
      step();
      bus.req0_valid = v.v0; bus.req0_store = v.st0; bus.req0_addr = v.a0; bus.req0_wdata = wpat(v.a0);
      bus.req1_valid = v.v1; bus.req1_store = v.st1; bus.req1_addr = v.a1; bus.req1_wdata = wpat(v.a1);
      exp_q.push_back({v.exp_store, v.exp_addr});
      step();
      @(negedge clk);
      check("vec_grant_valid", 128'(bus.mem_valid), 128'(1));
      check("vec_mem_rready", 128'(bus.mem_rready), 128'(!v.exp_port));
      for (int i = 0; i < v.lat; i++) begin
         step();
         if (v.exp_port) begin
            bus.req1_addr = ~v.a1; bus.req1_wdata = '1; bus.req1_store = ~v.st1;
         end else begin
            bus.req0_addr = ~v.a0; bus.req0_wdata = '1; bus.req0_store = ~v.st0;
         end
         bus.mem_wready = ~v.exp_store;
         bus.mem_rvalid = v.exp_store;
         @(negedge clk);
         check("vec_hold_addr", 128'(bus.mem_addr), 128'(v.exp_addr));
         check("vec_hold_store", 128'(bus.mem_store), 128'(v.exp_store));
         check_wide("vec_hold_wdata", bus.mem_wdata, wpat(v.exp_addr));
         check("vec_no_early_done",
               128'({bus.req1_wready, bus.req0_wready, bus.req1_rvalid, bus.req0_rvalid}), 128'(0));
      end
      step();
      bus.mem_wready = v.exp_store;
      bus.mem_rvalid = ~v.exp_store;
      bus.mem_rdata  = rd;
      @(negedge clk);
      check("vec_done",
            128'({bus.req1_wready, bus.req0_wready, bus.req1_rvalid, bus.req0_rvalid}),
            128'(v.exp_store ? (v.exp_port ? 4'b1000 : 4'b0100) : (v.exp_port ? 4'b0010 : 4'b0001)));
      if (!v.exp_store) check_wide("vec_rdata_win", v.exp_port ? bus.req1_rdata : bus.req0_rdata, rd);
      check_wide("vec_rdata_lose", v.exp_port ? bus.req0_rdata : bus.req1_rdata, '0);
      step();
      bus.mem_wready = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      if (v.exp_store) begin
         @(negedge clk);
         check("vec_inval", 128'({bus.inv1, bus.inv0, bus.mem_valid}), 128'(v.exp_port ? 3'b010 : 3'b100));
         check("vec_inval_addr", 128'(v.exp_port ? bus.inv0_addr : bus.inv1_addr), 128'(v.exp_addr));
         step();
      end
      @(negedge clk);
      check("vec_back_idle", 128'(bus.dbg_state), 128'(S_IDLE));
      check("vec_idle_quiet", 128'(any_out_main()), 128'(0));
   endtask

   // Both ports hold fill requests; grants must alternate starting at port 0.
   task automatic run_rr(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input int n);
      logic exp_p;
      step();
      bus.req0_valid = 1'b1; bus.req0_store = 1'b0; bus.req0_addr = a0; bus.req0_wdata = wpat(a0);
      bus.req1_valid = 1'b1; bus.req1_store = 1'b0; bus.req1_addr = a1; bus.req1_wdata = wpat(a1);
      for (int k = 0; k < n; k++) exp_q.push_back({1'b0, (k % 2 == 1) ? a1 : a0});
      for (int k = 0; k < n; k++) begin
         exp_p = (k % 2 == 1);
         wait_mem_valid("rr_wait");
         step();
         bus.mem_rvalid = 1'b1;
         bus.mem_rdata  = rpat(exp_p ? a1 : a0);
         @(negedge clk);
         check("rr_done", 128'({bus.req1_rvalid, bus.req0_rvalid}), 128'(exp_p ? 2'b10 : 2'b01));
         check_wide("rr_rdata", exp_p ? bus.req1_rdata : bus.req0_rdata, rpat(exp_p ? a1 : a0));
         step();
         bus.mem_rvalid = 1'b0;
         bus.mem_rdata  = '0;
      end
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      {bus.req0_valid, bus.req0_store, bus.req1_valid, bus.req1_store} = '0;
      bus.req0_rready = 1'b1; bus.req1_rready = 1'b0;
      bus.req0_addr = '0; bus.req1_addr = '0; bus.req0_wdata = '0; bus.req1_wdata = '0;
      bus.inv0_ack = 1'b1; bus.inv1_ack = 1'b1;
      bus.mem_rdata = '0; bus.mem_rvalid = 1'b0; bus.mem_wready = 1'b0;
      {nbus.req0_valid, nbus.req0_store, nbus.req1_valid, nbus.req1_store} = '0;
      nbus.req0_rready = 1'b0; nbus.req1_rready = 1'b0;
      nbus.req0_addr = '0; nbus.req1_addr = '0; nbus.req0_wdata = '0; nbus.req1_wdata = '0;
      nbus.inv0_ack = 1'b0; nbus.inv1_ack = 1'b0;
      nbus.mem_rdata = '0; nbus.mem_rvalid = 1'b0; nbus.mem_wready = 1'b0;

      //            v0    v1    st0   st1   a0          a1          lat port  store exp_addr
      vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 64'h1000, 64'h0,    3, 1'b0, 1'b0, 64'h1000};
      vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 64'h1100, 64'h2100, 1, 1'b1, 1'b0, 64'h2100};
      vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 64'h1200, 64'h2200, 0, 1'b0, 1'b0, 64'h1200};
      vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 64'h0,    64'h2040, 2, 1'b1, 1'b1, 64'h2040};
      vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 64'h1400, 64'h0,    1, 1'b0, 1'b1, 64'h1400};
      vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 64'h1500, 64'h0,    0, 1'b0, 1'b0, 64'h1500};
      vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 64'h1600, 64'h2600, 2, 1'b1, 1'b1, 64'h2600};
      vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 64'h1700, 64'h2700, 1, 1'b0, 1'b1, 64'h1700};

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_outs", 128'(any_out_main()), 128'(0));
      check("reset_state", 128'(bus.dbg_state), 128'(S_IDLE));
      step();
      reset = 1'b0;

      run_rr(64'h3000, 64'h4000, 4);

      for (int i = 0; i < 8; i++) run_vec(vecs[i]);

      // Store from port 1 with a slow invalidate ack; port 0 arrives meanwhile and waits.
      step();
      bus.req1_valid = 1'b1; bus.req1_store = 1'b1; bus.req1_addr = 64'h2040; bus.req1_wdata = wpat(64'h2040);
      bus.inv0_ack = 1'b0;
      exp_q.push_back({1'b1, 64'h2040});
      wait_mem_valid("snp_wait");
      step();
      bus.mem_wready = 1'b1;
      bus.req0_valid = 1'b1; bus.req0_store = 1'b0; bus.req0_addr = 64'h5000; bus.req0_wdata = wpat(64'h5000);
      @(negedge clk);
      check("snp_wready", 128'({bus.req1_wready, bus.req0_wready}), 128'(2'b10));
      step();
      bus.mem_wready = 1'b0;
      bus.req1_valid = 1'b0;
      exp_q.push_back({1'b0, 64'h5000});
      for (int i = 0; i < 5; i++) begin
         bus.inv0_ack = (i == 4);
         @(negedge clk);
         check("snp_inv0_held", 128'({bus.inv1, bus.inv0, bus.mem_valid}), 128'(3'b010));
         check("snp_inv0_addr", 128'(bus.inv0_addr), 128'(64'h2040));
         step();
      end
      bus.inv0_ack = 1'b1;
      @(negedge clk);
      check("snp_idle_after_ack", 128'({bus.dbg_state, bus.inv0, bus.mem_valid}), 128'({S_IDLE, 2'b00}));
      wait_mem_valid("snp_next_grant");
      step();
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = rpat(64'h5000);
      @(negedge clk);
      check("snp_next_done", 128'({bus.req1_rvalid, bus.req0_rvalid}), 128'(2'b01));
      step();
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = '0;
      bus.req0_valid = 1'b0;

      // Same store on the instance built without snooping: straight back to IDLE.
      step();
      nbus.req1_valid = 1'b1; nbus.req1_store = 1'b1; nbus.req1_addr = 64'h2040; nbus.req1_wdata = wpat(64'h2040);
      step();
      @(negedge clk);
      check("ns_grant", 128'({nbus.mem_valid, nbus.mem_store, nbus.mem_addr}), 128'({2'b11, 64'h2040}));
      step();
      nbus.mem_wready = 1'b1;
      @(negedge clk);
      check("ns_wready", 128'({nbus.req1_wready, nbus.req0_wready}), 128'(2'b10));
      step();
      nbus.mem_wready = 1'b0;
      nbus.req1_valid = 1'b0;
      @(negedge clk);
      check("ns_idle", 128'({nbus.dbg_state, nbus.inv0, nbus.inv1}), 128'({S_IDLE, 2'b00}));

      // Reset in the middle of a fill granted to port 0 (prio moves to 1 before reset).
      step();
      bus.req0_valid = 1'b1; bus.req0_store = 1'b0; bus.req0_addr = 64'h6000; bus.req0_wdata = wpat(64'h6000);
      exp_q.push_back({1'b0, 64'h6000});
      wait_mem_valid("rst_wait");
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      bus.req0_valid = 1'b0;
      @(negedge clk);
      check("rst_outs_zero", 128'(any_out_main()), 128'(0));
      check("rst_state", 128'(bus.dbg_state), 128'(S_IDLE));
      run_rr(64'h7000, 64'h8000, 2);

      step();
      step();
      check("sb_drained", 128'(exp_q.size()), 128'(0));
      check("ns_never_inval", 128'(ns_inv_seen), 128'(0));
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
